bu_pipe: RTL and testbench
==========================

# bu_pipe

Pipelined, parametrised branch execution unit for the out-of-order MIPS core. It accepts one branch/jump per cycle from the branch reservation station over a valid/ready handshake and resolves direction, target and link value for every `BUOp_*` operation in define.v. It compares the result against the fetch-stage prediction and flags mispredicts with the redirect PC. Results are buffered in a DEPTH-entry FIFO toward the ROB/CDB, and the unit keeps saturating branch and mispredict counters.

## Interface
- TAG_W, 6, ROB tag width
- DEPTH, 2, result FIFO entries (≥1; power of two not required)
- CNT_W, 16, statistics counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous pipeline flush from ROB
- in_valid  in  1  issue request
- in_ready  out  1  unit can accept this cycle
- in_op  in  6  `BUOp_*` code from define.v
- in_src1, in_src2  in  32  signed operands (rs, rt / old rd value for linking branches)
- in_imm  in  32  sign-extended immediate (or 26-bit index in [25:0] for J/Jal)
- in_pc_plus_4  in  32  PC of the branch + 4
- in_tag  in  TAG_W  ROB tag
- in_pred_taken  in  1  predicted direction
- in_pred_target  in  32  predicted target
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head
- out_tag  out  TAG_W  ROB tag of head
- out_taken  out  1  resolved direction
- out_target  out  32  resolved branch target
- out_mispredict  out  1  prediction wrong
- out_redirect_pc  out  32  correct next fetch PC
- out_link_we  out  1  writes link register
- out_link_data  out  32  value to write
- out_illegal  out  1  op not a `BUOp_*` code
- cnt_branch, cnt_mispred  out  CNT_W  saturating statistics

## Operation
- Accept when in_valid && in_ready. Resolve combinationally, then push into the FIFO at that edge.
- pc8 = in_pc_plus_4 + 4, with 32-bit wrap.
- J/Jal:
  - taken = 1.
  - target = {pc4[31:28], imm[25:0], 2'b00}.
- Conditional branches:
  - target = pc4 + {imm[29:0], 2'b00}, modulo 2^32.
  - Beq: taken = src1 == src2.
  - Bne: taken = src1 != src2.
  - Bgtz: taken = src1 > 0.
  - Blez: taken = src1 ≤ 0.
  - Bltz/Bltzal: taken = src1 < 0.
  - Bgez/Bgezal: taken = src1 ≥ 0.
  - All comparisons are signed.
- Jr/Jalr: taken = 1, target = src1.
- Link:
  - Jal and Jalr: link_we = 1, data = pc8.
  - Bltzal and Bgezal: link_we = 1, data = taken ? pc8 : src2 (rd rewritten unchanged).
  - All other ops: link_we = 0, data = 0.
- Undefined op: taken = 0, target = 0, link_we = 0, illegal = 1.
- mispredict = (taken != pred_taken) || (taken && target != pred_target).
- redirect_pc = taken ? target : pc8 (delay slot always executes).
- Counters:
  - cnt_branch increments on every accept.
  - cnt_mispred increments on an accept with mispredict = 1.
  - Both saturate at all-ones and are not cleared by flush.
- Flush:
  - Empties the FIFO at the edge.
  - in_ready = 0 during the flush cycle; any in_valid in that cycle is dropped and not counted.
  - A pop in the flush cycle is ignored.

## Timing
- Latency: accepted at edge k, entry visible on out_* after edge k (1 cycle). Throughput is 1 per cycle.
- in_ready = !flush && (count < DEPTH || (out_valid && out_ready)), so simultaneous push and pop when full is allowed.
- Pop occurs when out_valid && out_ready. Order is strictly FIFO, and pointers wrap modulo DEPTH.
- Simultaneous push and pop when empty is not possible: the entry first appears the cycle after the push.
- out_* fields are 0 whenever out_valid = 0.
- Reset (asynchronous, any time, including mid-stream):
  - FIFO empty, out_valid = 0, all out_* = 0, counters = 0.
  - in_ready = 1 in the first cycle after rst_n rises.

## Test plan
- Beq, src1 = src2 = 5, pc4 = 0x100, imm = 3, pred_taken = 1, pred_target = 0x10C -> next cycle: taken = 1, target = 0x10C, mispredict = 0, cnt_branch = 1.
- Bgezal, src1 = -1, src2 = 0xAA, pc4 = 0x200, pred_taken = 1 -> taken = 0, link_we = 1, link_data = 0xAA, mispredict = 1, redirect_pc = 0x204, cnt_mispred = 1.
- Jalr, src1 = 0x4000, pc4 = 0x300, pred_target = 0x4004 -> taken = 1, mispredict = 1, redirect_pc = 0x4000, link_data = 0x304.
- DEPTH = 2, out_ready = 0, three back-to-back issues -> in_ready drops after the 2nd. Then out_ready = 1 with in_valid held -> push and pop in the same cycle, and tags emerge in issue order.
- Flush with 2 entries queued and in_valid = 1 -> next cycle out_valid = 0, the flush-cycle input is not counted, and in_ready = 1 after.
- Drive rst_n low mid-stream, asynchronously to clk -> out_valid and counters read 0 immediately; set CNT_W = 2 and issue 5 branches -> cnt_branch holds at 3.

Source files
------------

// File: rtl/bu_pipe_if.sv
// Issue/result handshake bundle between the branch reservation station, the
// branch execution unit and the ROB/CDB consumer.
interface bu_pipe_if #(
    parameter int TAG_W = 6
) ();
    // Issue side
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_op;
    logic [31:0]      in_src1;
    logic [31:0]      in_src2;
    logic [31:0]      in_imm;
    logic [31:0]      in_pc_plus_4;
    logic [TAG_W-1:0] in_tag;
    logic             in_pred_taken;
    logic [31:0]      in_pred_target;

    // Result side (FIFO head)
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic             out_taken;
    logic [31:0]      out_target;
    logic             out_mispredict;
    logic [31:0]      out_redirect_pc;
    logic             out_link_we;
    logic [31:0]      out_link_data;
    logic             out_illegal;

    // Issuer and consumer side
    modport master (
        output in_valid, in_op, in_src1, in_src2, in_imm, in_pc_plus_4,
               in_tag, in_pred_taken, in_pred_target, out_ready,
        input  in_ready, out_valid, out_tag, out_taken, out_target,
               out_mispredict, out_redirect_pc, out_link_we, out_link_data,
               out_illegal
    );

    // Branch unit side
    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_imm, in_pc_plus_4,
               in_tag, in_pred_taken, in_pred_target, out_ready,
        output in_ready, out_valid, out_tag, out_taken, out_target,
               out_mispredict, out_redirect_pc, out_link_we, out_link_data,
               out_illegal
    );
endinterface

// File: rtl/bu_pipe.sv
// Branch execution unit: resolves direction, target and link value of one
// branch/jump per cycle, flags mispredicts against the fetch prediction and
// queues results in a DEPTH-entry FIFO toward the ROB/CDB. Keeps saturating
// branch and mispredict statistics.
module bu_pipe #(
    parameter int TAG_W = 6,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    bu_pipe_if.slave         bus,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_mispred
);
    // Branch unit opcodes
    localparam logic [5:0] BU_OP_J      = 6'd1;
    localparam logic [5:0] BU_OP_JAL    = 6'd2;
    localparam logic [5:0] BU_OP_JR     = 6'd3;
    localparam logic [5:0] BU_OP_JALR   = 6'd4;
    localparam logic [5:0] BU_OP_BEQ    = 6'd5;
    localparam logic [5:0] BU_OP_BNE    = 6'd6;
    localparam logic [5:0] BU_OP_BGTZ   = 6'd7;
    localparam logic [5:0] BU_OP_BLEZ   = 6'd8;
    localparam logic [5:0] BU_OP_BLTZ   = 6'd9;
    localparam logic [5:0] BU_OP_BGEZ   = 6'd10;
    localparam logic [5:0] BU_OP_BLTZAL = 6'd11;
    localparam logic [5:0] BU_OP_BGEZAL = 6'd12;

    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]    LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             taken;
        logic [31:0]      target;
        logic             mispredict;
        logic [31:0]      redirect_pc;
        logic             link_we;
        logic [31:0]      link_data;
        logic             illegal;
    } result_t;

    result_t             res;
    result_t             head;
    result_t             mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_BITS-1:0] count;
    logic                head_valid;
    logic                push;
    logic                pop;
    logic [31:0]         pc8;
    logic [31:0]         br_target;
    logic [31:0]         j_target;
    logic                src1_neg;
    logic                src1_zero;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Resolve the issuing branch: direction, target, link and mispredict.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        pc8       = bus.in_pc_plus_4 + 32'd4;
        br_target = bus.in_pc_plus_4 + {bus.in_imm[29:0], 2'b00};
        j_target  = {bus.in_pc_plus_4[31:28], bus.in_imm[25:0], 2'b00};
        src1_neg  = bus.in_src1[31];
        src1_zero = (bus.in_src1 == 32'd0);
        res       = '0;
        res.tag   = bus.in_tag;
        case (bus.in_op)
            BU_OP_J: begin
                res.taken  = 1'b1;
                res.target = j_target;
            end
            BU_OP_JAL: begin
                res.taken     = 1'b1;
                res.target    = j_target;
                res.link_we   = 1'b1;
                res.link_data = pc8;
            end
            BU_OP_JR: begin
                res.taken  = 1'b1;
                res.target = bus.in_src1;
            end
            BU_OP_JALR: begin
                res.taken     = 1'b1;
                res.target    = bus.in_src1;
                res.link_we   = 1'b1;
                res.link_data = pc8;
            end
            BU_OP_BEQ: begin
                res.taken  = (bus.in_src1 == bus.in_src2);
                res.target = br_target;
            end
            BU_OP_BNE: begin
                res.taken  = (bus.in_src1 != bus.in_src2);
                res.target = br_target;
            end
            BU_OP_BGTZ: begin
                res.taken  = !src1_neg && !src1_zero;
                res.target = br_target;
            end
            BU_OP_BLEZ: begin
                res.taken  = src1_neg || src1_zero;
                res.target = br_target;
            end
            BU_OP_BLTZ: begin
                res.taken  = src1_neg;
                res.target = br_target;
            end
            BU_OP_BGEZ: begin
                res.taken  = !src1_neg;
                res.target = br_target;
            end
            BU_OP_BLTZAL: begin
                // Not-taken linking branches rewrite rd with its old value.
                res.taken     = src1_neg;
                res.target    = br_target;
                res.link_we   = 1'b1;
                res.link_data = src1_neg ? pc8 : bus.in_src2;
            end
            BU_OP_BGEZAL: begin
                res.taken     = !src1_neg;
                res.target    = br_target;
                res.link_we   = 1'b1;
                res.link_data = !src1_neg ? pc8 : bus.in_src2;
            end
            default: res.illegal = 1'b1;
        endcase
        res.mispredict  = (res.taken != bus.in_pred_taken) ||
                          (res.taken && (res.target != bus.in_pred_target));
        // The delay slot always executes, so the fall-through PC is pc+8.
        res.redirect_pc = res.taken ? res.target : pc8;
    end

    // Handshake: a full FIFO still accepts when its head leaves this cycle.
    assign head_valid   = (count != '0);
    assign pop          = head_valid && bus.out_ready && !flush;
    assign bus.in_ready = !flush && ((count < FULL_CNT) || (head_valid && bus.out_ready));
    assign push         = bus.in_valid && bus.in_ready;

    // FIFO pointers and occupancy; flush empties the queue.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Result storage.
    // NOTE: storage is not reset; empty slots are never visible because the head is masked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= res;
    end

    // Saturating statistics, untouched by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_branch  <= '0;
            cnt_mispred <= '0;
        end else if (push) begin
            if (cnt_branch != '1) cnt_branch <= cnt_branch + 1'b1;
            if (res.mispredict && (cnt_mispred != '1)) cnt_mispred <= cnt_mispred + 1'b1;
        end
    end

    // Head of queue drives the result bus; all fields read zero when empty.
    assign head                = head_valid ? mem[rd_ptr] : '0;
    assign bus.out_valid       = head_valid;
    assign bus.out_tag         = head.tag;
    assign bus.out_taken       = head.taken;
    assign bus.out_target      = head.target;
    assign bus.out_mispredict  = head.mispredict;
    assign bus.out_redirect_pc = head.redirect_pc;
    assign bus.out_link_we     = head.link_we;
    assign bus.out_link_data   = head.link_data;
    assign bus.out_illegal     = head.illegal;
endmodule

// File: tb/tb_bu_pipe.sv
// Scoreboard bench for bu_pipe: the driver pushes model results into a queue
// on every accept, a separate monitor pops and compares on every pop.
module tb_bu_pipe;
    localparam int TAG_W = 6;

    localparam logic [5:0] OP_J      = 6'd1;
    localparam logic [5:0] OP_JAL    = 6'd2;
    localparam logic [5:0] OP_JR     = 6'd3;
    localparam logic [5:0] OP_JALR   = 6'd4;
    localparam logic [5:0] OP_BEQ    = 6'd5;
    localparam logic [5:0] OP_BNE    = 6'd6;
    localparam logic [5:0] OP_BGTZ   = 6'd7;
    localparam logic [5:0] OP_BLEZ   = 6'd8;
    localparam logic [5:0] OP_BLTZ   = 6'd9;
    localparam logic [5:0] OP_BGEZ   = 6'd10;
    localparam logic [5:0] OP_BLTZAL = 6'd11;
    localparam logic [5:0] OP_BGEZAL = 6'd12;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             taken;
        logic [31:0]      target;
        logic             mis;
        logic [31:0]      redirect;
        logic             lwe;
        logic [31:0]      ldata;
        logic             illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [15:0] cnt_branch, cnt_mispred;
    logic [1:0]  sat_branch, sat_mispred;

    always #5 clk = ~clk;

    bu_pipe_if #(.TAG_W(TAG_W)) bus ();
    bu_pipe_if #(.TAG_W(TAG_W)) bus2 ();

    bu_pipe #(.TAG_W(TAG_W), .DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
        .cnt_branch(cnt_branch), .cnt_mispred(cnt_mispred)
    );

    bu_pipe #(.TAG_W(TAG_W), .DEPTH(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .bus(bus2),
        .cnt_branch(sat_branch), .cnt_mispred(sat_mispred)
    );

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cb_m = 0;
    int   cm_m = 0;
    bit   rand_ready = 1'b0;
    logic [5:0] op_tab [12] = '{OP_J, OP_JAL, OP_JR, OP_JALR, OP_BEQ, OP_BNE,
                                OP_BGTZ, OP_BLEZ, OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference model: MIPS branch semantics in plain integer arithmetic.
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] s1, input logic [31:0] s2,
                                   input logic [31:0] imm, input logic [31:0] pc4, input logic pt,
                                   input logic [31:0] ptgt, input logic [TAG_W-1:0] tag);
        exp_t e;
        int a;
        longint t;
        logic [31:0] pc8;
        logic [31:0] rel;
        bit cond;
        e = '0;
        e.tag = tag;
        a = s1;
        pc8 = pc4 + 32'd4;
        t = longint'(pc4) + 64'd4 * longint'($signed(imm));
        rel = t[31:0];
        cond = 1'b1;
        case (op)
            OP_J, OP_JAL: begin
                e.taken = 1'b1;
                e.target = (pc4 & 32'hF000_0000) | ((imm & 32'h03FF_FFFF) << 2);
                cond = 1'b0;
            end
            OP_JR, OP_JALR: begin
                e.taken = 1'b1;
                e.target = s1;
                cond = 1'b0;
            end
            OP_BEQ:              e.taken = (s1 == s2);
            OP_BNE:              e.taken = (s1 != s2);
            OP_BGTZ:             e.taken = (a > 0);
            OP_BLEZ:             e.taken = (a <= 0);
            OP_BLTZ, OP_BLTZAL:  e.taken = (a < 0);
            OP_BGEZ, OP_BGEZAL:  e.taken = (a >= 0);
            default: begin
                e.illegal = 1'b1;
                cond = 1'b0;
            end
        endcase
        if (cond) e.target = rel;
        if (op == OP_JAL || op == OP_JALR) begin
            e.lwe = 1'b1;
            e.ldata = pc8;
        end else if (op == OP_BLTZAL || op == OP_BGEZAL) begin
            e.lwe = 1'b1;
            e.ldata = e.taken ? pc8 : s2;
        end
        e.mis = (e.taken != pt) || (e.taken && e.target != ptgt);
        e.redirect = e.taken ? e.target : pc8;
        return e;
    endfunction

    function automatic exp_t dut_head();
        exp_t h;
        h.tag      = bus.out_tag;
        h.taken    = bus.out_taken;
        h.target   = bus.out_target;
        h.mis      = bus.out_mispredict;
        h.redirect = bus.out_redirect_pc;
        h.lwe      = bus.out_link_we;
        h.ldata    = bus.out_link_data;
        h.illegal  = bus.out_illegal;
        return h;
    endfunction

    // Stimulus side of the scoreboard: counters check and expected-result push.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("cnt_branch", 128'(cnt_branch), 128'(cb_m));
                check("cnt_mispred", 128'(cnt_mispred), 128'(cm_m));
                if (flush) begin
                    exp_q.delete();
                end else if (bus.in_valid && bus.in_ready) begin
                    e = model(bus.in_op, bus.in_src1, bus.in_src2, bus.in_imm, bus.in_pc_plus_4,
                              bus.in_pred_taken, bus.in_pred_target, bus.in_tag);
                    exp_q.push_back(e);
                    if (cb_m < 65535) cb_m++;
                    if (e.mis && cm_m < 65535) cm_m++;
                end
            end
        end
    end

    // Monitor: compare every popped head, and all-zero fields when empty.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !flush) begin
                if (bus.out_valid) begin
                    if (bus.out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("spurious_out", 128'(1), 128'(0));
                        end else begin
                            e = exp_q.pop_front();
                            check("head", 128'(dut_head()), 128'(e));
                        end
                    end
                end else begin
                    check("idle_zero", 128'(dut_head()), 128'(0));
                end
            end
        end
    end

    // Random consumer backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [5:0] op, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] imm, input logic [31:0] pc4, input logic pt,
                          input logic [31:0] ptgt, input logic [TAG_W-1:0] tag);
        bus.in_op = op;
        bus.in_src1 = s1;
        bus.in_src2 = s2;
        bus.in_imm = imm;
        bus.in_pc_plus_4 = pc4;
        bus.in_pred_taken = pt;
        bus.in_pred_target = ptgt;
        bus.in_tag = tag;
    endtask

    // Hold one request until accepted (bounded), leaving time at posedge+1.
    task automatic issue(input logic [5:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] imm, input logic [31:0] pc4, input logic pt,
                         input logic [31:0] ptgt, input logic [TAG_W-1:0] tag);
        bit ok;
        ok = 1'b0;
        set_in(op, s1, s2, imm, pc4, pt, ptgt, tag);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0;
        if (!ok) check("issue_timeout", 128'(0), 128'(1));
    endtask

    task automatic expect_head(input string name, input exp_t e);
        @(negedge clk);
        check(name, 128'(dut_head()), 128'(e));
        step();
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !bus.out_valid;
        end
        check("drain", 128'(done), 128'(1));
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus2.in_valid = 1'b0;
        exp_q.delete();
        cb_m = 0;
        cm_m = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        logic [5:0]  op;
        logic [31:0] s1, s2, imm, pc4, ptgt;
        logic        pt;

        set_in(6'd0, '0, '0, '0, '0, 1'b0, '0, '0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus2.in_valid = 1'b0;
        bus2.out_ready = 1'b1;
        bus2.in_op = OP_BEQ;
        bus2.in_src1 = 32'd7;
        bus2.in_src2 = 32'd7;
        bus2.in_imm = 32'd1;
        bus2.in_pc_plus_4 = 32'h1000;
        bus2.in_tag = '0;
        bus2.in_pred_taken = 1'b0;
        bus2.in_pred_target = '0;

        do_reset();
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_cnt_branch", 128'(cnt_branch), 128'(0));
        check("rst_cnt_mispred", 128'(cnt_mispred), 128'(0));
        bus.out_ready = 1'b1;
        step();

        // Directed cases with hand-derived results.
        issue(OP_BEQ, 32'd5, 32'd5, 32'd3, 32'h100, 1'b1, 32'h10C, 6'd1);
        expect_head("beq", '{tag: 6'd1, taken: 1'b1, target: 32'h10C, mis: 1'b0,
                             redirect: 32'h10C, lwe: 1'b0, ldata: 32'h0, illegal: 1'b0});
        check("beq_cnt_branch", 128'(cnt_branch), 128'(1));

        issue(OP_BGEZAL, 32'hFFFF_FFFF, 32'hAA, 32'd4, 32'h200, 1'b1, 32'h210, 6'd2);
        expect_head("bgezal", '{tag: 6'd2, taken: 1'b0, target: 32'h210, mis: 1'b1,
                                redirect: 32'h204, lwe: 1'b1, ldata: 32'hAA, illegal: 1'b0});
        check("bgezal_cnt_mispred", 128'(cnt_mispred), 128'(1));

        issue(OP_JALR, 32'h4000, 32'h0, 32'h0, 32'h300, 1'b1, 32'h4004, 6'd3);
        expect_head("jalr", '{tag: 6'd3, taken: 1'b1, target: 32'h4000, mis: 1'b1,
                              redirect: 32'h4000, lwe: 1'b1, ldata: 32'h304, illegal: 1'b0});

        issue(6'd63, 32'h1, 32'h2, 32'h3, 32'h500, 1'b1, 32'h600, 6'd4);
        expect_head("illegal", '{tag: 6'd4, taken: 1'b0, target: 32'h0, mis: 1'b1,
                                 redirect: 32'h504, lwe: 1'b0, ldata: 32'h0, illegal: 1'b1});
        check("illegal_cnt_mispred", 128'(cnt_mispred), 128'(3));

        // Fill the FIFO, then push and pop in the same cycle while full.
        bus.out_ready = 1'b0;
        issue(OP_J, 32'h0, 32'h0, 32'h0123_4567, 32'hA000_0000, 1'b1, 32'hA48D_159C, 6'd10);
        issue(OP_BNE, 32'd1, 32'd2, 32'hFFFF_FFFE, 32'h800, 1'b0, 32'h0, 6'd11);
        set_in(OP_JAL, 32'h0, 32'h0, 32'h40, 32'h900, 1'b1, 32'h100, 6'd12);
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("full_in_ready", 128'(bus.in_ready), 128'(0));
        step();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("full_push_pop_ready", 128'(bus.in_ready), 128'(1));
        step();
        bus.in_valid = 1'b0;
        wait_drain();

        // Flush with two entries queued and a request on the bus.
        bus.out_ready = 1'b0;
        issue(OP_BLTZ, 32'hFFFF_FFF0, 32'h0, 32'h8, 32'h1000, 1'b1, 32'h1020, 6'd20);
        issue(OP_BGTZ, 32'h0, 32'h0, 32'h8, 32'h1100, 1'b0, 32'h0, 6'd21);
        set_in(OP_BLEZ, 32'h0, 32'h0, 32'h8, 32'h1200, 1'b1, 32'h1220, 6'd22);
        bus.in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 128'(bus.in_ready), 128'(0));
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_empty", 128'(bus.out_valid), 128'(0));
        check("flush_not_counted", 128'(cnt_branch), 128'(9));
        check("flush_in_ready_after", 128'(bus.in_ready), 128'(1));
        step();

        // Asynchronous reset in the middle of a stream.
        set_in(OP_BEQ, 32'd1, 32'd1, 32'd2, 32'h2000, 1'b0, 32'h0, 6'd30);
        bus.in_valid = 1'b1;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 128'(bus.out_valid), 128'(0));
        check("arst_cnt_branch", 128'(cnt_branch), 128'(0));
        check("arst_cnt_mispred", 128'(cnt_mispred), 128'(0));
        do_reset();
        check("arst_in_ready", 128'(bus.in_ready), 128'(1));
        step();

        // Randomized traffic with random backpressure and occasional flushes.
        rand_ready = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 13);
            op = (r < 12) ? op_tab[r] : 6'($urandom_range(0, 63));
            case ($urandom_range(0, 3))
                0:       s1 = 32'h0;
                1:       s1 = $urandom;
                2:       s1 = 32'($urandom_range(0, 6)) - 32'd3;
                default: s1 = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            endcase
            s2 = ($urandom_range(0, 2) == 0) ? s1 : $urandom;
            imm = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
            pc4 = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            pt = 1'($urandom_range(0, 1));
            ptgt = $urandom;
            if ($urandom_range(0, 1) != 0) begin
                e = model(op, s1, s2, imm, pc4, 1'b0, 32'h0, '0);
                pt = e.taken;
                ptgt = e.target;
            end
            r = $urandom_range(0, 15);
            if (r == 0) begin
                set_in(op, s1, s2, imm, pc4, pt, ptgt, 6'(n));
                bus.in_valid = 1'($urandom_range(0, 1));
                flush = 1'b1;
                step();
                flush = 1'b0;
                bus.in_valid = 1'b0;
            end else if (r < 4) begin
                step();
            end else begin
                issue(op, s1, s2, imm, pc4, pt, ptgt, 6'(n));
            end
        end
        rand_ready = 1'b0;
        #1;
        bus.out_ready = 1'b1;
        wait_drain();

        // Saturation of a 2-bit counter instance.
        bus2.in_valid = 1'b1;
        repeat (5) step();
        bus2.in_valid = 1'b0;
        @(negedge clk);
        check("sat_cnt_branch", 128'(sat_branch), 128'(3));
        check("sat_cnt_mispred", 128'(sat_mispred), 128'(3));
        check("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
